// File: rtl/timer_clint_pkg.sv
// Shared definitions for the CLINT-style timer: register offsets, CTRL layout
// and helpers that move the CTRL struct to and from its 32-bit bus image.
package timer_clint_pkg;

  localparam logic [31:0] OFF_MTIME_LO = 32'h00;
  localparam logic [31:0] OFF_MTIME_HI = 32'h04;
  localparam logic [31:0] OFF_CTRL     = 32'h08;
  localparam logic [31:0] OFF_MSIP     = 32'h0C;
  localparam logic [31:0] OFF_CMP_BASE = 32'h10;
  localparam int unsigned CMP_STRIDE   = 8;

  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_DIV_LSB  = 8;
  localparam int unsigned CTRL_MASK_LSB = 24;
  localparam int unsigned DIV_MAX_W     = 16;
  localparam int unsigned MASK_MAX_W    = 8;

  typedef struct packed {
    logic [MASK_MAX_W-1:0] mask;
    logic [DIV_MAX_W-1:0]  div;
    logic                  en;
  } clint_ctrl_t;

  function automatic clint_ctrl_t ctrl_from_word(input logic [31:0] w);
    clint_ctrl_t c;
    c.en   = w[CTRL_EN_BIT];
    c.div  = w[CTRL_DIV_LSB +: DIV_MAX_W];
    c.mask = w[CTRL_MASK_LSB +: MASK_MAX_W];
    return c;
  endfunction

  function automatic logic [31:0] ctrl_to_word(input clint_ctrl_t c);
    logic [31:0] w;
    w = '0;
    w[CTRL_EN_BIT]                  = c.en;
    w[CTRL_DIV_LSB +: DIV_MAX_W]    = c.div;
    w[CTRL_MASK_LSB +: MASK_MAX_W]  = c.mask;
    return w;
  endfunction

  // Bits of CTRL that physically exist for a given configuration.
  function automatic logic [31:0] ctrl_impl_mask(input int unsigned ncmp,
                                                 input int unsigned presc_w);
    logic [31:0] m;
    m = '0;
    m[CTRL_EN_BIT] = 1'b1;
    for (int unsigned i = 0; i < presc_w; i++) m[CTRL_DIV_LSB + i] = 1'b1;
    for (int unsigned i = 0; i < ncmp; i++) m[CTRL_MASK_LSB + i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/timer_clint_if.sv
// Simple request/response register bus used by the timer block.
interface timer_clint_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        rvalid_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  rdata_o, rvalid_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output rdata_o, rvalid_o
  );
endinterface

// File: rtl/timer_prescaler.sv
// Divide-by-(DIV+1) tick generator; counter parks at 0 while disabled.
module timer_prescaler #(
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] div,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt_q;

  assign tick = en && (cnt_q == div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!en || clr || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/timer_clint.sv
// Machine timer / software interrupt block: 64-bit mtime with prescaler,
// NUM_CMP compare channels, MSIP bit and a registered read port.
module timer_clint
  import timer_clint_pkg::*;
#(
  parameter int unsigned NUM_CMP   = 2,
  parameter int unsigned PRESC_W   = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
  input  logic               clk,
  input  logic               rst,
  timer_clint_if.slave       bus,
  output logic [NUM_CMP-1:0] mtip_o,
  output logic               msip_o,
  output logic [63:0]        mtime_o
);

  localparam logic [31:0] WIN_BYTES  = OFF_CMP_BASE + 32'(CMP_STRIDE * NUM_CMP);
  localparam logic [31:0] CTRL_WMASK = ctrl_impl_mask(NUM_CMP, PRESC_W);
  localparam clint_ctrl_t CTRL_RST   = ctrl_from_word(32'hFF00_0001 & CTRL_WMASK);

  logic [31:0] off;
  logic        hit;
  logic        wr;
  logic        rd;
  logic        wr_mlo;
  logic        wr_mhi;
  logic        wr_ctrl;
  logic        wr_msip;
  logic        tick;

  clint_ctrl_t ctrl_q;
  logic [63:0] mtime_q;
  logic [31:0] shadow_q;
  logic        msip_q;
  logic [31:0] rdata_q;
  logic        rvalid_q;
  logic [31:0] rd_val;
  logic [63:0] cmp [NUM_CMP];

  // Unsigned subtraction makes addresses below the base wrap far outside the window.
  assign off     = bus.addr_i - BASE_ADDR;
  assign hit     = (off < WIN_BYTES) && (off[1:0] == 2'b00);
  assign wr      = bus.req_i && bus.we_i && hit;
  assign rd      = bus.req_i && !bus.we_i;
  assign wr_mlo  = wr && (off == OFF_MTIME_LO);
  assign wr_mhi  = wr && (off == OFF_MTIME_HI);
  assign wr_ctrl = wr && (off == OFF_CTRL);
  assign wr_msip = wr && (off == OFF_MSIP);

  timer_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (ctrl_q.en),
    .clr  (wr_ctrl),
    .div  (ctrl_q.div[PRESC_W-1:0]),
    .tick (tick)
  );

  // A bus write to either half of mtime takes priority over the tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q <= '0;
    end else if (wr_mlo) begin
      mtime_q[31:0] <= bus.wdata_i;
    end else if (wr_mhi) begin
      mtime_q[63:32] <= bus.wdata_i;
    end else if (tick) begin
      mtime_q <= mtime_q + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= CTRL_RST;
      msip_q <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl_q <= ctrl_from_word(bus.wdata_i & CTRL_WMASK);
      if (wr_msip) msip_q <= bus.wdata_i[0];
    end
  end

  always_comb begin
    rd_val = '0;
    if (hit) begin
      case (off)
        OFF_MTIME_LO: rd_val = mtime_q[31:0];
        OFF_MTIME_HI: rd_val = shadow_q;
        OFF_CTRL:     rd_val = ctrl_to_word(ctrl_q);
        OFF_MSIP:     rd_val = {31'b0, msip_q};
        default: begin
          for (int unsigned i = 0; i < NUM_CMP; i++) begin
            if (off == OFF_CMP_BASE + CMP_STRIDE * i) begin
              rd_val = cmp[i][31:0];
            end else if (off == OFF_CMP_BASE + CMP_STRIDE * i + 4) begin
              rd_val = cmp[i][63:32];
            end
          end
        end
      endcase
    end
  end

  // Reading mtime lo snapshots the upper half so the following hi read is coherent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      shadow_q <= '0;
    end else begin
      rvalid_q <= rd;
      if (rd) rdata_q <= rd_val;
      if (rd && hit && (off == OFF_MTIME_LO)) shadow_q <= mtime_q[63:32];
    end
  end

  for (genvar g = 0; g < NUM_CMP; g++) begin : g_cmp
    localparam logic [31:0] OFF_LO = OFF_CMP_BASE + 32'(CMP_STRIDE * g);
    localparam logic [31:0] OFF_HI = OFF_LO + 32'd4;

    logic [63:0] cmp_q;
    logic        mtip_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cmp_q  <= '1;
        mtip_q <= 1'b0;
      end else begin
        if (wr && (off == OFF_LO)) cmp_q[31:0]  <= bus.wdata_i;
        if (wr && (off == OFF_HI)) cmp_q[63:32] <= bus.wdata_i;
        mtip_q <= (mtime_q >= cmp_q) && ctrl_q.mask[g];
      end
    end

    assign cmp[g]    = cmp_q;
    assign mtip_o[g] = mtip_q;
  end

  assign bus.rdata_o  = rdata_q;
  assign bus.rvalid_o = rvalid_q;
  assign msip_o       = msip_q;
  assign mtime_o      = mtime_q;

endmodule

// File: tb/tb_timer_clint.sv
// Randomized and directed bench for timer_clint against a cycle-level reference model.
module tb_timer_clint;

  localparam int unsigned NC   = 2;
  localparam int unsigned PW   = 8;
  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam int unsigned WIN  = 16 + 8 * NC;

  logic          clk;
  logic          rst;
  logic [NC-1:0] mtip;
  logic          msip;
  logic [63:0]   mtime;

  timer_clint_if bus ();

  timer_clint #(
    .NUM_CMP   (NC),
    .PRESC_W   (PW),
    .BASE_ADDR (BASE)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .mtip_o  (mtip),
    .msip_o  (msip),
    .mtime_o (mtime)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [63:0]   m_mtime;
  logic [63:0]   m_cmp [NC];
  logic [31:0]   m_shadow;
  bit            m_en;
  int unsigned   m_div;
  logic [NC-1:0] m_mask;
  int unsigned   m_phase;
  bit            m_msip;
  logic [NC-1:0] m_mtip;
  bit            m_rvalid;
  logic [31:0]   m_rdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_mtime  = '0;
    for (int i = 0; i < NC; i++) m_cmp[i] = '1;
    m_shadow = '0;
    m_en     = 1'b1;
    m_div    = 0;
    m_mask   = '1;
    m_phase  = 0;
    m_msip   = 1'b0;
    m_mtip   = '0;
    m_rvalid = 1'b0;
    m_rdata  = '0;
  endfunction

  // One rising edge: everything observable is derived from the state before the edge.
  function automatic void model_step(input bit req, input bit we,
                                     input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0]   off;
    logic [31:0]   rv;
    logic [NC-1:0] nm;
    bit            hit, wr, tick, ctrl_wr, hi_half;
    int unsigned   ch;
    off     = addr - BASE;
    hit     = (off < WIN) && (off % 4 == 0);
    wr      = req && we && hit;
    ctrl_wr = wr && (off == 8);
    tick    = m_en && ((m_phase % (m_div + 1)) == m_div);
    ch      = (off >= 16) ? (off - 16) / 8 : 0;
    hi_half = (off % 8) == 4;
    for (int i = 0; i < NC; i++) nm[i] = (m_mtime >= m_cmp[i]) && m_mask[i];
    rv = '0;
    if (hit) begin
      if (off == 0)       rv = m_mtime[31:0];
      else if (off == 4)  rv = m_shadow;
      else if (off == 8)  rv = (32'(m_mask) << 24) | (m_div << 8) | 32'(m_en);
      else if (off == 12) rv = {31'b0, m_msip};
      else                rv = hi_half ? m_cmp[ch][63:32] : m_cmp[ch][31:0];
    end
    m_rvalid = req && !we;
    if (m_rvalid) begin
      m_rdata = rv;
      if (hit && off == 0) m_shadow = m_mtime[63:32];
    end
    m_mtip  = nm;
    m_phase = (!m_en || ctrl_wr) ? 0 : m_phase + 1;
    if (wr && off == 0)      m_mtime[31:0]  = wd;
    else if (wr && off == 4) m_mtime[63:32] = wd;
    else if (tick)           m_mtime        = m_mtime + 64'd1;
    if (ctrl_wr) begin
      m_en   = wd[0];
      m_div  = (wd >> 8) & ((1 << PW) - 1);
      m_mask = NC'((wd >> 24) & ((1 << NC) - 1));
    end
    if (wr && off == 12) m_msip = wd[0];
    if (wr && off >= 16) begin
      if (hi_half) m_cmp[ch][63:32] = wd;
      else         m_cmp[ch][31:0]  = wd;
    end
  endfunction

  task automatic compare_outputs();
    check("mtime", mtime, m_mtime);
    check("mtip", 64'(mtip), 64'(m_mtip));
    check("msip", 64'(msip), 64'(m_msip));
    check("rvalid", 64'(bus.rvalid_o), 64'(m_rvalid));
    if (m_rvalid) check("rdata", 64'(bus.rdata_o), 64'(m_rdata));
  endtask

  task automatic cycle(input bit req, input bit we, input logic [31:0] addr, input logic [31:0] wd);
    bus.req_i   = req;
    bus.we_i    = we;
    bus.addr_i  = addr;
    bus.wdata_i = wd;
    @(posedge clk);
    model_step(req, we, addr, wd);
    @(negedge clk);
    compare_outputs();
    bus.req_i = 1'b0;
    bus.we_i  = 1'b0;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, BASE, 32'h0);
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    cycle(1'b1, 1'b1, BASE + off, d);
  endtask

  task automatic rd(input logic [31:0] off);
    cycle(1'b1, 1'b0, BASE + off, 32'h0);
  endtask

  logic [31:0] offs [12] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14,
                             32'h18, 32'h1C, 32'h20, 32'h02, 32'h24, 32'hFFFF_FFFC};

  initial begin
    logic [63:0] m0;
    logic [31:0] o, d;
    int          n;
    rst         = 1'b1;
    bus.req_i   = 1'b0;
    bus.we_i    = 1'b0;
    bus.addr_i  = '0;
    bus.wdata_i = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_mtime", mtime, 64'd0);
    check("rst_mtip", 64'(mtip), 64'd0);
    check("rst_msip", 64'(msip), 64'd0);
    check("rst_rvalid", 64'(bus.rvalid_o), 64'd0);
    check("rst_rdata", 64'(bus.rdata_o), 64'd0);
    rst = 1'b0;

    // Free-running at DIV=0
    repeat (10) idle();
    check("run10_mtime", mtime, 64'd10);
    check("run10_mtip", 64'(mtip), 64'd0);
    rd(32'h08);
    check("ctrl_reset", 64'(bus.rdata_o), 64'h0300_0001);

    // DIV=3: one tick per four cycles, then a mid-count DIV change
    wr(32'h08, 32'h0300_0301);
    m0 = mtime;
    repeat (16) idle();
    check("div3_16cyc", mtime, m0 + 64'd4);
    repeat (2) idle();
    wr(32'h08, 32'h0300_0201);
    m0 = mtime;
    repeat (2) idle();
    check("div2_hold", mtime, m0);
    idle();
    check("div2_tick", mtime, m0 + 64'd1);
    wr(32'h08, 32'h0300_0001);

    // Atomic 64-bit read across a carry
    wr(32'h04, 32'h0);
    wr(32'h00, 32'hFFFF_FFFF);
    rd(32'h00);
    check("carry_lo", 64'(bus.rdata_o), 64'hFFFF_FFFF);
    rd(32'h04);
    check("carry_hi_shadow", 64'(bus.rdata_o), 64'd0);
    rd(32'h00);
    rd(32'h04);
    check("carry_hi_new", 64'(bus.rdata_o), 64'd1);

    // Masked compare on channel 1
    wr(32'h08, 32'h0000_0001);
    wr(32'h1C, 32'h0);
    wr(32'h18, 32'd20);
    wr(32'h04, 32'h0);
    wr(32'h00, 32'h0);
    wr(32'h08, 32'h0200_0001);
    n = 0;
    while (mtime != 64'd20 && n < 40) begin
      idle();
      n++;
    end
    check("reach20", mtime, 64'd20);
    check("mtip_at20", 64'(mtip), 64'd0);
    idle();
    check("mtip_at21", 64'(mtip), 64'b10);
    wr(32'h08, 32'h0000_0001);
    idle();
    check("mtip_masked", 64'(mtip), 64'd0);

    // 64-bit wrap drops the interrupt
    wr(32'h08, 32'h0300_0001);
    wr(32'h14, 32'h0);
    wr(32'h10, 32'd5);
    wr(32'h04, 32'hFFFF_FFFF);
    wr(32'h00, 32'hFFFF_FFFF);
    idle();
    check("wrap_mtime", mtime, 64'd0);
    idle();
    check("wrap_mtip0", 64'(mtip[0]), 64'd0);

    // Write wins over tick; rst during a read
    wr(32'h00, 32'd100);
    check("wr_over_tick", 64'(mtime[31:0]), 64'd100);
    bus.req_i  = 1'b1;
    bus.we_i   = 1'b0;
    bus.addr_i = BASE;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_rvalid", 64'(bus.rvalid_o), 64'd0);
    check("rst_mid_rdata", 64'(bus.rdata_o), 64'd0);
    check("rst_mid_mtime", mtime, 64'd0);
    model_reset();
    @(negedge clk);
    bus.req_i = 1'b0;
    rst = 1'b0;

    // MSIP and unmapped accesses
    wr(32'h0C, 32'hFFFF_FFFF);
    check("msip_set", 64'(msip), 64'd1);
    rd(32'h0C);
    check("msip_rd", 64'(bus.rdata_o), 64'd1);
    wr(32'h20, 32'h1234_5678);
    rd(32'h20);
    check("unmapped_rd", 64'(bus.rdata_o), 64'd0);
    cycle(1'b1, 1'b0, BASE - 32'd4, 32'h0);
    check("below_base_rd", 64'(bus.rdata_o), 64'd0);

    // Randomized traffic
    for (int k = 0; k < 500; k++) begin
      o = offs[$urandom_range(0, 11)];
      d = $urandom;
      if (o == 32'h08) begin
        d = d & 32'hFFFF_00FE;
        d = d | ($urandom_range(0, 3) << 8) | 32'($urandom_range(0, 4) != 0);
      end else if (o == 32'h00 && $urandom_range(0, 3) == 0) begin
        d = 32'hFFFF_FFF0 | $urandom_range(0, 15);
      end else if (o == 32'h10 || o == 32'h18) begin
        d = m_mtime[31:0] + $urandom_range(0, 40);
      end else if (o == 32'h14 || o == 32'h1C) begin
        d = m_mtime[63:32] + $urandom_range(0, 1);
      end
      case ($urandom_range(0, 9))
        0, 1, 2: idle();
        3, 4, 5: cycle(1'b1, 1'b0, BASE + o, 32'h0);
        default: cycle(1'b1, 1'b1, BASE + o, d);
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/timer_clint.md
TIMER_CLINT -- requirements
Module: timer_clint

Interface
REQ-001 SHALL have parameter NUM_CMP, default 2, number of independent mtimecmp channels (legal 1..8).
REQ-002 SHALL have parameter PRESC_W, default 8, prescaler divisor width in bits (legal 1..16).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0200_0000, byte base of register window.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 req_i  in  1  bus access request, one-cycle pulse per access.
REQ-007 we_i  in  1  write when 1, read when 0; qualified by req_i.
REQ-008 addr_i  in  32  byte address, word-aligned.
REQ-009 wdata_i  in  32  write data.
REQ-010 rdata_o  out  32  read data, registered.
REQ-011 rvalid_o  out  1  read data valid, one-cycle pulse.
REQ-012 mtip_o  out  NUM_CMP  per-channel timer interrupt pending, registered level.
REQ-013 msip_o  out  1  software interrupt pending.
REQ-014 mtime_o  out  64  current mtime, debug/CSR time shadow.

Function
REQ-015 Offset map from BASE_ADDR: 0x00 mtime lo, 0x04 mtime hi, 0x08 CTRL, 0x0C MSIP, 0x10+8*i mtimecmp[i] lo, 0x14+8*i mtimecmp[i] hi.
REQ-016 CTRL bit0 = EN, bits[PRESC_W+7:8] = DIV, bits[23+NUM_CMP:24] = per-channel MASK; unimplemented bits read 0.
REQ-017 Prescaler counter SHALL count 0..DIV, wrap to 0, and assert tick in the cycle it equals DIV; DIV=0 gives tick every cycle.
REQ-018 mtime SHALL increment by 1 on each tick while EN=1; 2^64-1 wraps to 0.
REQ-019 EN=0 SHALL freeze mtime and hold prescaler counter at 0.
REQ-020 Write to DIV SHALL reset prescaler counter to 0 in the same cycle.
REQ-021 Bus write to mtime lo/hi SHALL replace that half and suppress the increment that cycle (write wins over tick).
REQ-022 Read of mtime lo SHALL capture mtime[63:32] into a hi-shadow register; read of mtime hi SHALL return the shadow, giving an atomic 64-bit read.
REQ-023 Reads SHALL return data one cycle after req_i with rvalid_o=1 for exactly one cycle; writes produce no rvalid_o.
REQ-024 Access outside the window or to an unmapped offset SHALL read 0 and ignore writes.
REQ-025 mtip_o[i] SHALL be registered (mtime >= mtimecmp[i]) AND MASK[i], unsigned 64-bit compare, updated every cycle.
REQ-026 Write to mtimecmp[i] SHALL take effect on the compare in the following cycle; mtip_o[i] SHALL not assert from the partially written value if software first writes hi = 32'hFFFF_FFFF.
REQ-027 MSIP bit0 SHALL be read/write and drive msip_o directly from the register.
REQ-028 Back-to-back req_i on consecutive cycles SHALL be accepted without stall.

Reset
REQ-029 On rst: mtime=0, prescaler=0, hi-shadow=0, all mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, EN=1, DIV=0, MASK=all ones, MSIP=0.
REQ-030 On rst: rdata_o=0, rvalid_o=0, mtip_o=0, msip_o=0; rst mid-read SHALL drop the pending rvalid_o.

Structure
REQ-031 Shared package SHALL hold offset constants, CTRL field positions, and a clint_ctrl_t packed struct.
REQ-032 One sub-module timer_prescaler (counter, DIV, EN in; tick out) SHALL be instantiated; compare channels generated by a generate loop.

Verification
REQ-033 Reset then EN=1, DIV=0, run 10 cycles -> mtime=10, mtip_o=0, msip_o=0.
REQ-034 DIV=3, run 16 cycles -> mtime advanced by 4; write DIV mid-count -> next tick DIV+1 cycles later.
REQ-035 mtime=32'hFFFF_FFFF lo, 0 hi, read lo then hi after carry tick -> hi read returns 0 (shadow), next lo read then hi returns 1.
REQ-036 mtimecmp[1]=20, MASK=2'b10, mtime from 0 -> mtip_o=2'b10 from cycle mtime=20 plus 1; set MASK=0 -> mtip_o clears next cycle.
REQ-037 mtime=64'hFFFF_FFFF_FFFF_FFFF, tick -> mtime=0 and mtip_o drops for mtimecmp=5.
REQ-038 Write mtime lo=100 in tick cycle -> mtime=100 next cycle; assert rst during read -> rvalid_o=0.
